// File: rtl/rle_dec_if.sv
// AXI4-Stream style bundle for the RLE decoder input and output streams.
// W is the tdata width of the particular stream instance.
interface rle_dec_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: expands {cnt, dat} words into cnt+1 samples of dat.
// A single holding register feeds the output, so ready propagates combinationally.
module rle_dec #(
    parameter int CW = 8,
    parameter int DW = 8,
    parameter int SW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_rst,
    input  logic          cfg_ena,
    rle_dec_if.slave      sti,
    rle_dec_if.master     sto,
    output logic [SW-1:0] sts_cnt
);
    logic          hld_vld;
    logic          hld_lst;
    logic [DW-1:0] hld_dat;
    logic [CW-1:0] hld_rem;

    logic last_smp;
    logic in_xfer;
    logic out_xfer;

    assign last_smp = (hld_rem == '0);

    assign sti.tready = ~ctl_rst & (~hld_vld | (sto.tready & last_smp));
    assign in_xfer    = sti.tvalid & sti.tready;
    assign out_xfer   = hld_vld & sto.tready;

    assign sto.tvalid = hld_vld;
    assign sto.tdata  = hld_dat;
    assign sto.tlast  = hld_vld & hld_lst & last_smp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hld_vld <= 1'b0;
            hld_lst <= 1'b0;
            hld_dat <= '0;
            hld_rem <= '0;
            sts_cnt <= '0;
        end else if (ctl_rst) begin
            // Drops any partly expanded run; data is left as-is since vld is low.
            hld_vld <= 1'b0;
            hld_lst <= 1'b0;
            hld_rem <= '0;
            sts_cnt <= '0;
        end else begin
            if (out_xfer) begin
                sts_cnt <= sts_cnt + 1'b1;
            end
            if (in_xfer) begin
                hld_vld <= 1'b1;
                hld_dat <= sti.tdata[DW-1:0];
                hld_rem <= cfg_ena ? sti.tdata[CW+DW-1:DW] : '0;
                hld_lst <= sti.tlast;
            end else if (out_xfer) begin
                if (last_smp) begin
                    hld_vld <= 1'b0;
                end else begin
                    hld_rem <= hld_rem - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rle_dec.sv
// Directed bench for rle_dec with hand-computed expected samples.
module tb_rle_dec;
    logic        clk = 1'b0;
    logic        rst;
    logic        ctl_rst;
    logic        cfg_ena;
    logic [31:0] sts_cnt;

    int nvec = 0;
    int nerr = 0;

    rle_dec_if #(.W(16)) sti_if ();
    rle_dec_if #(.W(8))  sto_if ();

    rle_dec #(.CW(8), .DW(8), .SW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctl_rst (ctl_rst),
        .cfg_ena (cfg_ena),
        .sti     (sti_if),
        .sto     (sto_if),
        .sts_cnt (sts_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ctl_rst = 1'b1;
        step();
        ctl_rst = 1'b0;
    endtask

    logic [15:0] words [3];
    logic [7:0]  smps  [3];
    logic        rdy_pat [5];
    logic        lst_pat [5];
    int          n;
    int          rdy_idx;
    logic [7:0]  held;

    initial begin
        rst = 1'b1;
        ctl_rst = 1'b0;
        cfg_ena = 1'b1;
        sti_if.tdata = '0;
        sti_if.tvalid = 1'b0;
        sti_if.tlast = 1'b0;
        sto_if.tready = 1'b1;
        #12;
        chk("rst_vld", sto_if.tvalid, 0);
        chk("rst_lst", sto_if.tlast, 0);
        chk("rst_dat", sto_if.tdata, 0);
        chk("rst_sts", sts_cnt, 0);
        chk("rst_rdy", sti_if.tready, 1);
        rst = 1'b0;
        step();

        // cnt=3 with tlast: four samples, tlast on the fourth
        sti_if.tdata = 16'h03A5;
        sti_if.tlast = 1'b1;
        sti_if.tvalid = 1'b1;
        step();
        sti_if.tvalid = 1'b0;
        sti_if.tlast = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("r4_vld%0d", k), sto_if.tvalid, 1);
            chk($sformatf("r4_dat%0d", k), sto_if.tdata, 8'hA5);
            chk($sformatf("r4_lst%0d", k), sto_if.tlast, (k == 3));
            chk($sformatf("r4_rdy%0d", k), sti_if.tready, (k == 3));
            step();
        end
        chk("r4_end", sto_if.tvalid, 0);
        chk("r4_sts", sts_cnt, 4);

        // bypass: count ignored, back-to-back single samples
        clr();
        chk("clr_sts", sts_cnt, 0);
        cfg_ena = 1'b0;
        words = '{16'h0311, 16'hFF22, 16'h0033};
        smps  = '{8'h11, 8'h22, 8'h33};
        sti_if.tdata = words[0];
        sti_if.tvalid = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) sti_if.tdata = words[k+1];
            else sti_if.tvalid = 1'b0;
            #1;
            chk($sformatf("byp_vld%0d", k), sto_if.tvalid, 1);
            chk($sformatf("byp_dat%0d", k), sto_if.tdata, smps[k]);
            if (k < 2) chk($sformatf("byp_rdy%0d", k), sti_if.tready, 1);
            step();
        end
        chk("byp_end", sto_if.tvalid, 0);
        chk("byp_sts", sts_cnt, 3);

        // max count: 256 samples, input held off until the last
        clr();
        cfg_ena = 1'b1;
        sti_if.tdata = 16'hFF5A;
        sti_if.tvalid = 1'b1;
        step();
        sti_if.tdata = 16'h0077;
        n = 0;
        rdy_idx = -1;
        for (int i = 0; i < 256; i++) begin
            if (sto_if.tvalid && sto_if.tdata == 8'h5A) n++;
            if (sti_if.tready && rdy_idx < 0) rdy_idx = i;
            step();
        end
        chk("r256_n", n, 256);
        chk("r256_rdy", rdy_idx, 255);
        sti_if.tvalid = 1'b0;
        chk("r256_nxt", sto_if.tdata, 8'h77);
        step();
        chk("r256_end", sto_if.tvalid, 0);
        chk("r256_sts", sts_cnt, 257);

        // stalls: tready 1,0,1,0,1 over a cnt=2 run with tlast
        clr();
        sti_if.tdata = 16'h02C3;
        sti_if.tlast = 1'b1;
        sti_if.tvalid = 1'b1;
        step();
        sti_if.tvalid = 1'b0;
        sti_if.tlast = 1'b0;
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        lst_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            sto_if.tready = rdy_pat[k];
            #1;
            chk($sformatf("stl_vld%0d", k), sto_if.tvalid, 1);
            chk($sformatf("stl_dat%0d", k), sto_if.tdata, 8'hC3);
            chk($sformatf("stl_lst%0d", k), sto_if.tlast, lst_pat[k]);
            step();
        end
        sto_if.tready = 1'b1;
        chk("stl_end", sto_if.tvalid, 0);
        chk("stl_sts", sts_cnt, 3);

        // cfg_ena dropped right after acceptance must not shorten the run
        clr();
        sti_if.tdata = 16'h0266;
        sti_if.tvalid = 1'b1;
        step();
        sti_if.tvalid = 1'b0;
        cfg_ena = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (sto_if.tvalid) n++;
            step();
        end
        chk("ena_n", n, 3);
        cfg_ena = 1'b1;

        // ctl_rst after 2 of 6 samples
        clr();
        sti_if.tdata = 16'h05E1;
        sti_if.tvalid = 1'b1;
        step();
        sti_if.tdata = 16'h0199;
        step();
        step();
        chk("cr_mid", sts_cnt, 2);
        ctl_rst = 1'b1;
        #1;
        chk("cr_rdy", sti_if.tready, 0);
        step();
        ctl_rst = 1'b0;
        chk("cr_vld", sto_if.tvalid, 0);
        chk("cr_sts", sts_cnt, 0);
        step();
        sti_if.tvalid = 1'b0;
        chk("cr_dat0", sto_if.tdata, 8'h99);
        chk("cr_rdy0", sti_if.tready, 0);
        step();
        chk("cr_dat1", sto_if.tdata, 8'h99);
        chk("cr_vld1", sto_if.tvalid, 1);
        step();
        chk("cr_end", sto_if.tvalid, 0);
        chk("cr_sts2", sts_cnt, 2);

        // async rst mid-run, between clock edges
        sti_if.tdata = 16'h0477;
        sti_if.tvalid = 1'b1;
        step();
        sti_if.tvalid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_vld", sto_if.tvalid, 0);
        chk("ar_dat", sto_if.tdata, 0);
        chk("ar_sts", sts_cnt, 0);
        #1;
        rst = 1'b0;
        step();
        chk("ar_rdy", sti_if.tready, 1);
        chk("ar_sts2", sts_cnt, 0);
        chk("ar_vld2", sto_if.tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
